fht_unload: RTL and testbench
=============================

// Module: fht_unload
// PURPOSE
//  Downstream of fht_top. After the transform finishes, reads the four RAM(A) banks through fht_top's external read ports.
//  Emits the N result points as a single-word valid/ready stream in natural index order, at up to 1 word/clk.
//  Buffers RAM lines so that downstream backpressure never loses or duplicates a point.
// PARAMETERS
//  D_BIT  `D_BIT (22)  signed word width of fht_top result
//  A_BIT  `A_BIT (8)   per-bank address width; N = 4*2^A_BIT points
// PORTS
//  iCLK      in   1          system clock, single clock domain
//  iRESET    in   1          asynchronous, active-low reset
//  iSTART    in   1          1-clk pulse: begin unload (tie to rise of fht_top oRDY)
//  oADDR_RD  out  A_BIT      common read addr, drives fht_top iADDR_RD_0..3
//  iDATA_0   in   D_BIT      fht_top oDATA_0 (bank 0), 1-clk registered read latency
//  iDATA_1   in   D_BIT      bank 1
//  iDATA_2   in   D_BIT      bank 2
//  iDATA_3   in   D_BIT      bank 3
//  oDATA     out  D_BIT      output point, signed
//  oIDX      out  A_BIT+2    index n of oDATA
//  oVALID    out  1          oDATA/oIDX valid
//  iREADY    in   1          sink accepts; transfer = oVALID & iREADY
//  oLAST     out  1          high with the word n = N-1
//  oBUSY     out  1          unload in progress
//  oDONE     out  1          1-clk pulse after last transfer
// BEHAVIOUR
//  Mapping: point n sits in bank n[1:0] at address n[A_BIT+1:2]. One read yields 4 consecutive points.
//  Reset (iRESET=0, async): all outputs 0; FSM IDLE; buffers empty; counters 0.
//  FSM IDLE -> RUN on iSTART. RUN -> DRAIN when the last address (2^A_BIT-1) has been issued.
//   DRAIN -> IDLE when the word N-1 transfers, with oDONE=1 on the next clk.
//  oBUSY = (state != IDLE). iSTART in RUN/DRAIN is ignored.
//  Fetch: oADDR_RD is registered. A read is issued only when (lines held + reads in flight) < 2.
//   Issue happens in the iSTART clk +1. Data is sampled 1 clk after the address is presented.
//  Line buffer: 2 entries x 4 words. Word select 0..3 walks banks 0,1,2,3; the entry pops after word 3 transfers.
//  Latency: iSTART at clk t -> oADDR_RD=0 at t+1 -> line captured t+2 -> oVALID=1 (n=0) at t+3.
//  Throughput: with iREADY held high, oVALID stays high for exactly N consecutive clks, n = 0..N-1.
//  Backpressure: while oVALID & !iREADY, oDATA/oIDX/oLAST are held stable. No fetch is issued if the buffer would overflow.
//  Simultaneous pop and line capture in the same clk is legal; occupancy is unchanged.
//  Address counter wraps only at the end of the transform. After DRAIN, oADDR_RD returns to 0.
//  iREADY low at the last word: remain in DRAIN, with oLAST and oVALID held until accepted.
//  oIDX increments by 1 per transfer, 0..N-1, and never wraps within a run.
//  Data is passed unmodified (no scaling, no sign change).
//  Mid-run reset: async clear to reset state. A partial stream is abandoned; the sink must discard it.
// STRUCTURE
//  fht_defines.v: D_BIT, A_BIT defaults; FSM state codes UNL_IDLE/UNL_RUN/UNL_DRAIN.
//  Sub-module fht_unload_buf: 2-entry x (4*D_BIT) FIFO.
//   Ports: push, pop, line in, 4-word line out, count[1:0].
//  Top holds the FSM, address counter, in-flight flag, word select and index counter.
// TESTING
//  A_BIT=3 (N=32), RAM model bank k addr a = 4a+k:
//  1 iSTART pulse, iREADY=1 -> oVALID first at t+3; 32 consecutive words with oDATA=oIDX=0..31; oLAST at 31; oDONE at t+35.
//  2 iREADY toggles 1,0 each clk -> 32 words in order, no gap/dup; outputs stable while stalled; oADDR_RD never >1 line ahead.
//  3 iREADY=0 for 20 clks from t+3 -> exactly 2 lines fetched then reads stop; release -> n=0..31 intact.
//  4 iSTART repeated at t+5 -> ignored; one stream of 32 words, one oDONE.
//  5 iRESET low at word 10 -> all outputs 0 at once; new iSTART -> restarts at n=0.
//  6 Negative data (bank words = -(4a+k)) -> oDATA matches, sign preserved at D_BIT width.

Source files
------------

// File: rtl/fht_unload_pkg.sv
// Shared constants for the FHT result unloader: default widths, FSM state codes
// and the fetch-credit helper used to keep the two-line buffer from overflowing.
package fht_unload_pkg;

   localparam int D_BIT_DEF = 22;
   localparam int A_BIT_DEF = 8;

   localparam logic [1:0] UNL_IDLE  = 2'd0;
   localparam logic [1:0] UNL_RUN   = 2'd1;
   localparam logic [1:0] UNL_DRAIN = 2'd2;

   localparam logic [2:0] LINE_DEPTH = 3'd2;

   // Lines already held plus reads still travelling through the RAM pipeline.
   function automatic logic [2:0] lines_committed(input logic [1:0] held,
                                                  input logic       rd_addr_stage,
                                                  input logic       rd_data_stage);
      return {1'b0, held} + {2'b00, rd_addr_stage} + {2'b00, rd_data_stage};
   endfunction

endpackage

// File: rtl/fht_unload_if.sv
// Bus between fht_unload, the fht_top external read ports and the result sink.
// The master modport is the unloader's view; slave is the environment's view.
interface fht_unload_if
   import fht_unload_pkg::*;
#(
   parameter int D_BIT = D_BIT_DEF,
   parameter int A_BIT = A_BIT_DEF
);
   logic               iSTART;
   logic [A_BIT-1:0]   oADDR_RD;
   logic [D_BIT-1:0]   iDATA_0;
   logic [D_BIT-1:0]   iDATA_1;
   logic [D_BIT-1:0]   iDATA_2;
   logic [D_BIT-1:0]   iDATA_3;
   logic [D_BIT-1:0]   oDATA;
   logic [A_BIT+1:0]   oIDX;
   logic               oVALID;
   logic               iREADY;
   logic               oLAST;
   logic               oBUSY;
   logic               oDONE;

   modport master (
      input  iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
      output oADDR_RD, oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
   );

   modport slave (
      output iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
      input  oADDR_RD, oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
   );
endinterface

// File: rtl/fht_unload_buf.sv
// Two-entry FIFO of RAM lines (four words per line). A push while full is
// accepted only if an entry pops in the same clock.
module fht_unload_buf
   import fht_unload_pkg::*;
#(
   parameter int D_BIT = D_BIT_DEF
) (
   input  logic               iCLK,
   input  logic               iRESET,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [4*D_BIT-1:0] i_line,
   output logic [4*D_BIT-1:0] o_line,
   output logic [1:0]         o_count
);
   logic [4*D_BIT-1:0] r_mem [2];
   logic               r_wp;
   logic               r_rp;
   logic [1:0]         r_count;
   logic               w_push;
   logic               w_pop;

   // Qualify push/pop against occupancy.
   always_comb begin
      w_pop  = i_pop & (r_count != 2'd0);
      w_push = i_push & ((r_count != 2'd2) | w_pop);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_mem[0] <= {(4*D_BIT){1'b0}};
         r_mem[1] <= {(4*D_BIT){1'b0}};
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= i_line;
         end
         r_wp    <= r_wp ^ w_push;
         r_rp    <= r_rp ^ w_pop;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Head entry and occupancy out.
   always_comb begin
      o_line  = r_mem[r_rp];
      o_count = r_count;
   end
endmodule

// File: rtl/fht_unload.sv
// Reads the four RAM(A) banks of fht_top one line at a time and emits the N
// result points in natural order on a valid/ready stream.
module fht_unload
   import fht_unload_pkg::*;
#(
   parameter int D_BIT = D_BIT_DEF,
   parameter int A_BIT = A_BIT_DEF
) (
   input  logic         iCLK,
   input  logic         iRESET,
   fht_unload_if.master bus
);
   localparam int               IDX_W    = A_BIT + 2;
   localparam logic [A_BIT-1:0] ADDR_MAX = {A_BIT{1'b1}};
   localparam logic [IDX_W-1:0] IDX_MAX  = {IDX_W{1'b1}};

   logic [1:0]         r_state;
   logic [A_BIT-1:0]   r_addr;
   logic               r_rd_addr;
   logic               r_rd_data;
   logic [1:0]         r_wsel;
   logic [IDX_W-1:0]   r_idx;
   logic               r_done;

   logic [1:0]         w_state_nxt;
   logic [A_BIT-1:0]   w_addr_nxt;
   logic [1:0]         w_count;
   logic [4*D_BIT-1:0] w_line;
   logic               w_start;
   logic               w_fetch;
   logic               w_issue;
   logic               w_valid;
   logic               w_xfer;
   logic               w_pop;
   logic               w_last;

   // r_rd_addr: address on the RAM this clk; r_rd_data: its data arrives now.
   fht_unload_buf #(.D_BIT(D_BIT)) u_buf (
      .iCLK    (iCLK),
      .iRESET  (iRESET),
      .i_push  (r_rd_data),
      .i_pop   (w_pop),
      .i_line  ({bus.iDATA_3, bus.iDATA_2, bus.iDATA_1, bus.iDATA_0}),
      .o_line  (w_line),
      .o_count (w_count)
   );

   // Handshake, fetch-credit and end-of-stream decode.
   always_comb begin
      w_valid = (w_count != 2'd0);
      w_xfer  = w_valid & bus.iREADY;
      w_pop   = w_xfer & (r_wsel == 2'd3);
      w_last  = w_valid & (r_idx == IDX_MAX);
      w_start = (r_state == UNL_IDLE) & bus.iSTART;
      w_fetch = (r_state == UNL_RUN) &
                (lines_committed(w_count, r_rd_addr, r_rd_data) < LINE_DEPTH);
      w_issue = w_start | w_fetch;
   end

   // Next state and next read address.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      case (r_state)
         UNL_IDLE: begin
            if (w_start) begin
               w_state_nxt = UNL_RUN;
               w_addr_nxt  = {A_BIT{1'b0}};
            end else begin
               w_state_nxt = UNL_IDLE;
            end
         end
         UNL_RUN: begin
            if (w_fetch) begin
               w_addr_nxt  = r_addr + A_BIT'(1);
               w_state_nxt = (w_addr_nxt == ADDR_MAX) ? UNL_DRAIN : UNL_RUN;
            end else begin
               w_state_nxt = UNL_RUN;
            end
         end
         UNL_DRAIN: begin
            if (w_xfer && w_last) begin
               w_state_nxt = UNL_IDLE;
               w_addr_nxt  = {A_BIT{1'b0}};
            end else begin
               w_state_nxt = UNL_DRAIN;
            end
         end
         default: begin
            w_state_nxt = UNL_IDLE;
            w_addr_nxt  = {A_BIT{1'b0}};
         end
      endcase
   end

   // FSM, read pipeline tracking, word select and index counters.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         r_state   <= UNL_IDLE;
         r_addr    <= {A_BIT{1'b0}};
         r_rd_addr <= 1'b0;
         r_rd_data <= 1'b0;
         r_wsel    <= 2'd0;
         r_idx     <= {IDX_W{1'b0}};
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_rd_addr <= w_issue;
         r_rd_data <= r_rd_addr;
         r_done    <= (r_state == UNL_DRAIN) & w_xfer & w_last;
         if (w_start) begin
            r_wsel <= 2'd0;
            r_idx  <= {IDX_W{1'b0}};
         end else if (w_xfer) begin
            r_wsel <= r_wsel + 2'd1;
            r_idx  <= r_idx + IDX_W'(1);
         end
      end
   end

   // Stream outputs: word r_wsel of the head line is bank r_wsel.
   always_comb begin
      bus.oADDR_RD = r_addr;
      bus.oDATA    = w_line[r_wsel*D_BIT +: D_BIT];
      bus.oIDX     = r_idx;
      bus.oVALID   = w_valid;
      bus.oLAST    = w_last;
      bus.oBUSY    = (r_state != UNL_IDLE);
      bus.oDONE    = r_done;
   end
endmodule

// File: tb/tb_fht_unload.sv
// Randomised bench for fht_unload (A_BIT=3, N=32): a RAM model feeds the DUT and
// a stream model (point n = bank n%4, addr n/4) checks every presented word.
module tb_fht_unload;
   localparam int D_BIT = 22;
   localparam int A_BIT = 3;
   localparam int NL    = 8;
   localparam int N     = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fht_unload_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();
   fht_unload #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (.iCLK(clk), .iRESET(rst_n), .bus(bus));

   logic [D_BIT-1:0] ram   [4][NL];
   logic [D_BIT-1:0] model [N];

   int n_checks   = 0;
   int n_fails    = 0;
   int cyc        = 0;
   int exp_n      = 0;
   int done_count = 0;
   int done_cyc   = 0;
   int first_cyc  = 0;
   int start_cyc  = 0;
   int run_id     = 0;
   int mon_run    = 0;

   logic             prev_valid = 1'b0;
   logic             prev_stall = 1'b0;
   logic [D_BIT-1:0] prev_data  = '0;
   logic [A_BIT+1:0] prev_idx   = '0;
   logic             prev_last  = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // fht_top read ports: one clock registered latency
   always @(posedge clk) begin
      bus.iDATA_0 <= ram[0][bus.oADDR_RD];
      bus.iDATA_1 <= ram[1][bus.oADDR_RD];
      bus.iDATA_2 <= ram[2][bus.oADDR_RD];
      bus.iDATA_3 <= ram[3][bus.oADDR_RD];
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_outputs", {bus.oVALID, bus.oLAST, bus.oBUSY, bus.oDONE,
                               bus.oIDX, bus.oADDR_RD, bus.oDATA}, 0);
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (run_id != mon_run) begin
            mon_run = run_id;
            exp_n   = 0;
         end
         if (prev_stall) begin
            check("hold_valid", bus.oVALID, 1);
            check("hold_word", {bus.oDATA, bus.oIDX, bus.oLAST},
                  {prev_data, prev_idx, prev_last});
         end
         if (bus.oVALID) begin
            if (!prev_valid && exp_n == 0) first_cyc = cyc;
            if (exp_n >= N) begin
               check("extra_word_idx", bus.oIDX, -1);
            end else begin
               check("data", bus.oDATA, model[exp_n]);
               check("idx", bus.oIDX, exp_n);
               check("last", bus.oLAST, (exp_n == N-1) ? 1 : 0);
               check("addr_ahead", (int'(bus.oADDR_RD) <= exp_n/4 + 1) ? 1 : 0, 1);
            end
         end else begin
            check("last_without_valid", bus.oLAST, 0);
         end
         if (bus.oDONE) begin
            done_count++;
            done_cyc = cyc;
            check("done_after_all", exp_n, N);
         end
         prev_stall = bus.oVALID & ~bus.iREADY;
         prev_valid = bus.oVALID;
         prev_data  = bus.oDATA;
         prev_idx   = bus.oIDX;
         prev_last  = bus.oLAST;
         if (bus.oVALID && bus.iREADY) exp_n++;
      end
   end

   task automatic fill(input int kind);
      int v;
      for (int a = 0; a < NL; a++) begin
         for (int k = 0; k < 4; k++) begin
            case (kind)
               0:       v = 4*a + k;
               1:       v = -(4*a + k);
               default: v = int'($urandom);
            endcase
            ram[k][a]      = D_BIT'(v);
            model[4*a + k] = D_BIT'(v);
         end
      end
   endtask

   function automatic logic rdy(input int mode, input int k);
      case (mode)
         1:       return (k % 2 == 0);
         2:       return !(k >= 3 && k < 23);
         3:       return ($urandom_range(0, 1) == 1);
         default: return 1'b1;
      endcase
   endfunction

   // mode: 0 ready=1, 1 toggling, 2 long stall, 3 random, 4 repeated start
   task automatic run(input int mode, input int kind);
      int k;
      int base;
      fill(kind);
      base = done_count;
      @(posedge clk); #1;
      run_id++;
      bus.iSTART = 1'b1;
      start_cyc  = cyc;
      bus.iREADY = rdy(mode, 0);
      k = 0;
      while (done_count == base && k < 300) begin
         @(posedge clk); #1;
         k++;
         bus.iSTART = (mode == 4 && k == 5);
         bus.iREADY = rdy(mode, k);
         if (mode == 2 && k == 22) begin
            check("stall_two_lines_addr", bus.oADDR_RD, 1);
            check("stall_idx", bus.oIDX, 0);
            check("stall_valid", bus.oVALID, 1);
         end
      end
      bus.iSTART = 1'b0;
      check("run_completed", done_count - base, 1);
      check("first_valid_latency", first_cyc - start_cyc, 3);
      if (mode == 0 || mode == 4) check("done_latency", done_cyc - start_cyc, 35);
      repeat (8) @(posedge clk);
      #1;
      check("idle_busy", bus.oBUSY, 0);
      check("idle_addr", bus.oADDR_RD, 0);
      check("single_done", done_count - base, 1);
      check("word_count", exp_n, N);
   endtask

   task automatic reset_mid_run();
      int k;
      fill(2);
      @(posedge clk); #1;
      run_id++;
      bus.iSTART = 1'b1;
      bus.iREADY = 1'b1;
      @(posedge clk); #1;
      bus.iSTART = 1'b0;
      k = 0;
      while (!(bus.oVALID && bus.oIDX == 10) && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      check("reached_word10", bus.oIDX, 10);
      rst_n = 1'b0;
      #1;
      check("async_clear", {bus.oVALID, bus.oLAST, bus.oBUSY, bus.oDONE,
                            bus.oIDX, bus.oADDR_RD, bus.oDATA}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [D_BIT-1:0] neg7;
      bus.iSTART = 1'b0;
      bus.iREADY = 1'b0;
      fill(0);
      check("pin_model_5", model[5], 5);
      check("pin_model_31", model[31], 31);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(0, 0);
      run(1, 2);
      run(2, 2);
      run(4, 0);
      run(3, 2);
      fill(1);
      neg7 = D_BIT'(-7);
      check("pin_model_neg7", model[7], neg7);
      check("pin_model_neg_sign", model[31][D_BIT-1], 1);
      run(0, 1);
      reset_mid_run();
      run(0, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
